alu_seq: RTL and testbench

Multi-byte operation sequencer for the 8-bit `alu`. It accepts one wide operation (NBYTES × 8 bits) per request over a valid/ready handshake. It then drives the combinational `alu` one byte per cycle, chaining `sc_o` → `sc_i` between bytes, and returns the wide result with carry/zero flags on a second valid/ready handshake. It sits between the core's execute control and the `alu` instance, and is the only driver of the `alu` inputs.

---
 rtl/alu_seq.sv | 106 ++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequences one NBYTES-wide operation through the 8-bit alu, one byte per cycle.
// Define ALUSEQ_CMP_EN to support op 4 (CMP) as wide unsigned A > B.
module alu_seq #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic [4:0]          alu_cmd,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_sc_i,
  input  logic [7:0]          alu_rslt,
  input  logic                alu_sc_o,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [8*NBYTES-1:0] resp_data,
  output logic                resp_carry,
  output logic                resp_zero,
  output logic                resp_cnd,
  output logic                resp_err,
  output logic                busy
);
  localparam int W = 8 * NBYTES;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_XOR = 5'd3,
                         OP_CMP = 5'd4, OP_LSL = 5'd6, OP_LSR = 5'd7, OP_MOV = 5'd8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state, w_next;
  logic [4:0]     r_op;
  logic [W-1:0]   r_a, r_b, r_res;
  logic [2:0]     r_idx;
  logic           r_chain, r_err, r_nz;
  logic           w_sup, w_cmp, w_sub, w_chain, w_run, w_done, w_last, w_acc, w_ok;
  logic [2:0]     w_bi;
  logic [5:0]     w_sh;
  logic [7:0]     w_bb;
`ifdef ALUSEQ_CMP_EN
  assign w_sup = req_op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_CMP, OP_LSL, OP_LSR, OP_MOV};
`else
  assign w_sup = req_op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LSL, OP_LSR, OP_MOV};
`endif
  assign w_run   = r_state == RUN;
  assign w_done  = r_state == DONE;
  assign w_acc   = r_state == IDLE && req_valid;
  assign w_last  = r_idx == LAST;
  assign w_cmp   = r_op == OP_CMP && !r_err;
  assign w_sub   = r_op == OP_SUB || w_cmp;
  assign w_chain = w_sub || r_op inside {OP_ADD, OP_LSL, OP_LSR};
  // LSR walks bytes MSB first so the shifted-out bit chains downward
  assign w_bi    = r_op == OP_LSR ? LAST - r_idx : r_idx;
  assign w_sh    = {w_bi, 3'b000};
  assign w_bb    = 8'(r_b >> w_sh);
  assign w_ok    = w_done && !r_err;
  assign alu_cmd    = w_run ? (w_sub ? OP_ADD : r_op) : 5'd0;
  assign alu_a      = w_run ? 8'(r_a >> w_sh) : 8'd0;
  assign alu_b      = w_run ? (w_sub ? ~w_bb : w_bb) : 8'd0;
  assign alu_sc_i   = w_run && (r_idx == 3'd0 ? w_sub : (w_chain && r_chain));
  assign req_ready  = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign resp_valid = w_done;
  assign resp_data  = w_ok ? (w_cmp ? r_a : r_res) : '0;
  assign resp_carry = w_ok && w_chain && r_chain;
  assign resp_zero  = w_ok && (w_cmp ? !r_nz : r_res == '0);
  assign resp_cnd   = w_ok && w_cmp && r_chain && r_nz;
  assign resp_err   = w_done && r_err;
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_sup ? RUN : DONE;
    else if (w_run && w_last) w_next = DONE;
    else if (w_done && resp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_chain <= 1'b0;
      r_err   <= 1'b0;
      r_nz    <= 1'b0;
    end else if (w_acc) begin
      r_op    <= req_op;
      r_a     <= req_a;
      r_b     <= req_b;
      r_res   <= '0;
      r_idx   <= '0;
      r_chain <= 1'b0;
      r_err   <= !w_sup;
      r_nz    <= 1'b0;
    end else if (w_run) begin
      r_idx   <= r_idx + 3'd1;
      r_chain <= alu_sc_o;
      r_nz    <= r_nz || alu_rslt != 8'd0;
      if (!w_cmp) r_res <= (r_res & ~(W'(8'hFF) << w_sh)) | (W'(alu_rslt) << w_sh);
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq (NBYTES=2) against a behavioural 8-bit alu.
module tb_alu_seq;
  logic        clk, rst_n, req_valid, req_ready, resp_valid, resp_ready;
  logic [4:0]  req_op, alu_cmd;
  logic [15:0] req_a, req_b, resp_data;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sc_i, alu_sc_o, resp_carry, resp_zero, resp_cnd, resp_err, busy;
  int checks = 0, failures = 0;
  alu_seq #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_carry(resp_carry), .resp_zero(resp_zero), .resp_cnd(resp_cnd),
    .resp_err(resp_err), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always_comb begin
    {alu_sc_o, alu_rslt} = 9'h0;
    case (alu_cmd)
      5'd0: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_sc_i};
      5'd2: alu_rslt = alu_a & alu_b;
      5'd3: alu_rslt = alu_a ^ alu_b;
      5'd6: {alu_sc_o, alu_rslt} = {alu_a, alu_sc_i};
      5'd7: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_a};
      5'd8: alu_rslt = alu_b;
      default: ;
    endcase
  end
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic end_resp();
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0; req_valid = 0; resp_ready = 0; req_op = 0; req_a = 0; req_b = 0;
    #23;
    checks++;
    if ({resp_valid, resp_data, resp_carry, resp_zero, resp_cnd, resp_err, busy, alu_cmd, alu_a, alu_b, alu_sc_i, req_ready} !== {39'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset: valid=%b data=%h busy=%b alu=%h/%h/%h req_ready=%b, required all 0 and req_ready=1", resp_valid, resp_data, busy, alu_cmd, alu_a, alu_b, req_ready);
    end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_add();
    @(negedge clk);
    req_valid = 1; req_op = 0; req_a = 16'h00FF; req_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if ({alu_cmd, alu_a, alu_b, alu_sc_i, busy, req_ready} !== {5'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_byte0: cmd=%h a=%h b=%h sci=%b busy=%b rdy=%b, required 0 ff 01 0 1 0", alu_cmd, alu_a, alu_b, alu_sc_i, busy, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({alu_a, alu_b, alu_sc_i, resp_valid} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_byte1: a=%h b=%h sci=%b valid=%b, required 00 00 1 0", alu_a, alu_b, alu_sc_i, resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_data, resp_carry, resp_zero, resp_err, alu_cmd, alu_a} !== {1'b1, 16'h0100, 3'b000, 5'd0, 8'd0}) begin
      failures++;
      $display("FAIL add_resp: valid=%b data=%h c=%b z=%b err=%b alu_a=%h, required 1 0100 0 0 0 00", resp_valid, resp_data, resp_carry, resp_zero, resp_err, alu_a);
    end
    end_resp();
  endtask
  task automatic test_sub();
    int lat;
    run_op(5'd1, 16'h0100, 16'h0001, lat);
    checks++;
    if ({lat[4:0], resp_data, resp_carry, resp_zero} !== {5'd2, 16'h00FF, 2'b10}) begin
      failures++;
      $display("FAIL sub_nb: lat=%0d data=%h c=%b z=%b, required 2 00ff 1 0", lat, resp_data, resp_carry, resp_zero);
    end
    end_resp();
    run_op(5'd1, 16'h0000, 16'h0001, lat);
    checks++;
    if ({lat[4:0], resp_data, resp_carry, resp_zero} !== {5'd2, 16'hFFFF, 2'b00}) begin
      failures++;
      $display("FAIL sub_borrow: lat=%0d data=%h c=%b z=%b, required 2 ffff 0 0", lat, resp_data, resp_carry, resp_zero);
    end
    end_resp();
  endtask
  task automatic test_shift();
    int lat;
    run_op(5'd6, 16'h8080, 16'h0000, lat);
    checks++;
    if ({lat[4:0], resp_data, resp_carry} !== {5'd2, 16'h0100, 1'b1}) begin
      failures++;
      $display("FAIL lsl: lat=%0d data=%h c=%b, required 2 0100 1", lat, resp_data, resp_carry);
    end
    end_resp();
    run_op(5'd7, 16'h0101, 16'h0000, lat);
    checks++;
    if ({lat[4:0], resp_data, resp_carry} !== {5'd2, 16'h0080, 1'b1}) begin
      failures++;
      $display("FAIL lsr: lat=%0d data=%h c=%b, required 2 0080 1", lat, resp_data, resp_carry);
    end
    end_resp();
  endtask
  task automatic test_logic();
    int lat;
    run_op(5'd2, 16'hF0F0, 16'h0F0F, lat);
    checks++;
    if ({lat[4:0], resp_data, resp_carry, resp_zero, resp_cnd} !== {5'd2, 16'h0000, 3'b010}) begin
      failures++;
      $display("FAIL and: lat=%0d data=%h c=%b z=%b cnd=%b, required 2 0000 0 1 0", lat, resp_data, resp_carry, resp_zero, resp_cnd);
    end
    end_resp();
    run_op(5'd3, 16'h1234, 16'h00FF, lat);
    checks++;
    if ({resp_data, resp_carry, resp_zero} !== {16'h12CB, 2'b00}) begin
      failures++;
      $display("FAIL xor: data=%h c=%b z=%b, required 12cb 0 0", resp_data, resp_carry, resp_zero);
    end
    end_resp();
  endtask
  task automatic test_back_to_back();
    int lat;
    run_op(5'd0, 16'h1234, 16'h0101, lat);
    resp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_data, resp_carry, resp_zero, req_ready} !== {1'b1, 16'h1335, 3'b000}) begin
        failures++;
        $display("FAIL stall_%0d: valid=%b data=%h c=%b z=%b rdy=%b, required 1 1335 0 0 0", i, resp_valid, resp_data, resp_carry, resp_zero, req_ready);
      end
      @(posedge clk); #1;
    end
    end_resp();
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_ready: rdy=%b valid=%b busy=%b, required 1 0 0", req_ready, resp_valid, busy);
    end
    req_valid = 1; req_op = 5'd8; req_a = 16'h0000; req_b = 16'hA55A;
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if ({busy, req_ready, alu_cmd, alu_b} !== {2'b10, 5'd8, 8'h5A}) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b rdy=%b cmd=%h b=%h, required 1 0 08 5a", busy, req_ready, alu_cmd, alu_b);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_data} !== {1'b1, 16'hA55A}) begin
      failures++;
      $display("FAIL b2b_mov: valid=%b data=%h, required 1 a55a", resp_valid, resp_data);
    end
    end_resp();
  endtask
  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    req_valid = 1; req_op = 0; req_a = 16'h00FF; req_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({resp_valid, resp_data, busy, alu_cmd, alu_a, alu_b, alu_sc_i, req_ready} !== {36'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid: valid=%b data=%h busy=%b alu=%h/%h/%h sci=%b rdy=%b, required all 0 and rdy=1", resp_valid, resp_data, busy, alu_cmd, alu_a, alu_b, alu_sc_i, req_ready);
    end
    @(negedge clk); rst_n = 1;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) lat++;
    end
    checks++;
    if (lat != 0) begin
      failures++;
      $display("FAIL reset_no_resp: resp_valid seen %0d cycles, required 0", lat);
    end
    run_op(5'd0, 16'h0001, 16'h0001, lat);
    checks++;
    if ({lat[4:0], resp_data} !== {5'd2, 16'h0002}) begin
      failures++;
      $display("FAIL reset_recover: lat=%0d data=%h, required 2 0002", lat, resp_data);
    end
    end_resp();
  endtask
  task automatic test_err();
    int lat;
    run_op(5'h0A, 16'h1234, 16'h5678, lat);
    checks++;
    if ({lat[4:0], resp_err, resp_data, resp_carry, resp_zero, resp_cnd} !== {5'd0, 1'b1, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL err_op: lat=%0d err=%b data=%h c=%b z=%b cnd=%b, required 0 1 0000 0 0 0", lat, resp_err, resp_data, resp_carry, resp_zero, resp_cnd);
    end
    end_resp();
  endtask
  task automatic test_cmp();
    int lat;
    run_op(5'd4, 16'h0200, 16'h01FF, lat);
    checks++;
`ifdef ALUSEQ_CMP_EN
    if ({lat[4:0], resp_err, resp_cnd, resp_data, resp_carry, resp_zero} !== {5'd2, 2'b01, 16'h0200, 2'b10}) begin
      failures++;
      $display("FAIL cmp: lat=%0d err=%b cnd=%b data=%h c=%b z=%b, required 2 0 1 0200 1 0", lat, resp_err, resp_cnd, resp_data, resp_carry, resp_zero);
    end
`else
    if ({lat[4:0], resp_err, resp_cnd, resp_data} !== {5'd0, 2'b10, 16'h0000}) begin
      failures++;
      $display("FAIL cmp_unsup: lat=%0d err=%b cnd=%b data=%h, required 0 1 0 0000", lat, resp_err, resp_cnd, resp_data);
    end
`endif
    end_resp();
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    test_err();
    test_cmp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
